window_spill_fill: RTL

Window spill/fill engine for the windowed register file. On a window overflow trap it reads the 16 windowed registers of one window out through a register-file read port and writes them to memory at that window's stack pointer (spill). On an underflow it reads 16 words from memory and writes them back into the register file through its write port (fill). It sits between the trap-handling control logic, the register file and the data-memory request interface.

---
 rtl/spill_fill_pkg.sv | 17 +
 rtl/window_spill_fill.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/spill_fill_pkg.sv
// Shared types and constants for the register-window spill/fill engine.
package spill_fill_pkg;

  localparam int REGS_PER_WIN = 16;
  localparam int WORD_BYTES   = 4;

  typedef enum logic [2:0] {
    IDLE,
    SP_RD,
    SP_REQ,
    FL_REQ,
    FL_WAIT,
    FL_WR,
    DONE
  } sf_state_t;

endpackage

// File: rtl/window_spill_fill.sv
// Moves one register window between the register file and memory: spill
// copies 16 registers out to the stack, fill copies 16 words back in.
module window_spill_fill #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int WIN_BITS     = 5,
  parameter int REGS_PER_WIN = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start_spill,
  input  logic                            start_fill,
  input  logic [WIN_BITS-1:0]             win,
  input  logic [ADDR_W-1:0]               sp,
  output logic                            busy,
  output logic                            done,
  output logic [WIN_BITS-1:0]             rf_rd_win,
  output logic [$clog2(REGS_PER_WIN)-1:0] rf_rd_idx,
  input  logic [DATA_W-1:0]               rf_rd_data,
  output logic                            rf_wr_en,
  output logic [WIN_BITS-1:0]             rf_wr_win,
  output logic [$clog2(REGS_PER_WIN)-1:0] rf_wr_idx,
  output logic [DATA_W-1:0]               rf_wr_data,
  output logic                            mem_req_valid,
  input  logic                            mem_req_ready,
  output logic                            mem_req_we,
  output logic [ADDR_W-1:0]               mem_req_addr,
  output logic [DATA_W-1:0]               mem_req_wdata,
  input  logic                            mem_rsp_valid,
  input  logic [DATA_W-1:0]               mem_rsp_data
);
  import spill_fill_pkg::*;

  localparam int                IDX_W    = $clog2(REGS_PER_WIN);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(REGS_PER_WIN - 1);

  sf_state_t           state;
  logic [WIN_BITS-1:0] win_q;
  logic [ADDR_W-1:0]   base_q;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;

  assign idx_nxt = idx + IDX_W'(1);

  // Byte address of word i in the latched window frame; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  i);
    return base + ADDR_W'(i) * ADDR_W'(WORD_BYTES);
  endfunction

  // NOTE: state and every output are updated with non-blocking assignments in one
  // clocked block, so all outputs are registered and reset drives them to 0 at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      win_q         <= '0;
      base_q        <= '0;
      idx           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rf_rd_win     <= '0;
      rf_rd_idx     <= '0;
      rf_wr_en      <= 1'b0;
      rf_wr_win     <= '0;
      rf_wr_idx     <= '0;
      rf_wr_data    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
    end else begin
      done     <= 1'b0;
      rf_wr_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_spill || start_fill) begin
            win_q  <= win;
            base_q <= sp & ~ADDR_W'(WORD_BYTES - 1);
            idx    <= '0;
            busy   <= 1'b1;
          end
          if (start_spill) begin
            rf_rd_win <= win;
            rf_rd_idx <= '0;
            state     <= SP_RD;
          end else if (start_fill) begin
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= sp & ~ADDR_W'(WORD_BYTES - 1);
            state         <= FL_REQ;
          end
        end
        SP_RD: begin
          mem_req_wdata <= rf_rd_data;
          mem_req_valid <= 1'b1;
          mem_req_we    <= 1'b1;
          mem_req_addr  <= word_addr(base_q, idx);
          state         <= SP_REQ;
        end
        SP_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx       <= idx_nxt;
              rf_rd_idx <= idx_nxt;
              state     <= SP_RD;
            end
          end
        end
        FL_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= FL_WAIT;
          end
        end
        FL_WAIT: begin
          if (mem_rsp_valid) begin
            rf_wr_en   <= 1'b1;
            rf_wr_win  <= win_q;
            rf_wr_idx  <= idx;
            rf_wr_data <= mem_rsp_data;
            state      <= FL_WR;
          end
        end
        FL_WR: begin
          if (idx == LAST_IDX) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx           <= idx_nxt;
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= word_addr(base_q, idx_nxt);
            state         <= FL_REQ;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
